sjr_method_runner: RTL and testbench

Synthesizable, parametrised method-sequencing harness for Synthesijer-generated modules. Generates the DUT reset pulse, then invokes NUM_CH methods one after another through their req/busy/return handshakes. Each return is compared against an expected value, with a per-method timeout. Pass/fail is reported as registered flags, so self-checking runs work both in simulation and on FPGA (LED/UART status).

---
 rtl/sjr_runner_pkg.sv | 18 +
 rtl/sjr_method_runner_if.sv | 14 +
 rtl/sjr_runner_sel.sv | 31 +++
 rtl/sjr_method_runner.sv | 140 ++++++++++++++
 tb/tb_sjr_method_runner.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sjr_runner_pkg.sv
// Shared types for the method runner: FSM state encoding and counter widths.
// No logic, no latency, no backpressure; imported by the runner and its select block.
package sjr_runner_pkg;

  localparam int CNT_W    = 32;
  localparam int CH_IDX_W = 5;

  typedef enum logic [2:0] {
    RST,
    WAIT,
    REQ,
    RUN,
    CHECK,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/sjr_method_runner_if.sv
// Method-call bundle between the runner and the Synthesijer DUT: one-hot req, busy, packed returns.
// Wires only, zero latency; the DUT throttles the runner by holding busy high.
interface sjr_method_runner_if #(
  parameter int NUM_CH = 4,
  parameter int RET_W  = 32
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*RET_W-1:0] ret;
  logic [NUM_CH*RET_W-1:0] expected;

  modport master (output req, input busy, input ret, input expected);
  modport slave  (input req, output busy, output ret, output expected);
endinterface

// File: rtl/sjr_runner_sel.sv
// Picks the busy bit, return slice and expected slice of the active channel.
// Purely combinational; an out-of-range index reads as busy so it can never complete.
module sjr_runner_sel
  import sjr_runner_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int RET_W  = 32
) (
  input  logic [CH_IDX_W-1:0]     cur_ch,
  input  logic [NUM_CH-1:0]       busy,
  input  logic [NUM_CH*RET_W-1:0] ret,
  input  logic [NUM_CH*RET_W-1:0] expected,
  output logic                    busy_sel,
  output logic [RET_W-1:0]        ret_sel,
  output logic [RET_W-1:0]        exp_sel
);

  always_comb begin
    busy_sel = 1'b1;
    ret_sel  = '0;
    exp_sel  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_ch == CH_IDX_W'(i)) begin
        busy_sel = busy[i];
        ret_sel  = ret[i*RET_W +: RET_W];
        exp_sel  = expected[i*RET_W +: RET_W];
      end
    end
  end

endmodule

// File: rtl/sjr_method_runner.sv
// Pulses the DUT reset, then calls each method in turn and checks its return; SJR_RUNNER_STOP_ON_FAIL_EN ends the run at the first failure.
// req lasts one cycle per channel, completion is busy low after MIN_WAIT cycles, bounded by TIMEOUT; results are registered flags.
module sjr_method_runner
  import sjr_runner_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int RET_W       = 32,
  parameter int RST_START   = 3,
  parameter int RST_END     = 8,
  parameter int START_CYCLE = 100,
  parameter int MIN_WAIT    = 4,
  parameter int TIMEOUT     = 10000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                dut_reset,
  sjr_method_runner_if.master bus,
  output logic [CH_IDX_W-1:0] cur_ch,
  output logic [CNT_W-1:0]    cycle,
  output logic                done,
  output logic                pass,
  output logic [NUM_CH-1:0]   fail_mask,
  output logic [NUM_CH-1:0]   timeout_mask
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   timer;
  logic [RET_W-1:0]   ret_q;
  logic               busy_sel;
  logic [RET_W-1:0]   ret_sel;
  logic [RET_W-1:0]   exp_sel;
  logic [NUM_CH-1:0]  ch_onehot;
  logic               run_done;
  logic               run_tmo;
  logic               last_ch;
  logic               stop_now;

  sjr_runner_sel #(
    .NUM_CH (NUM_CH),
    .RET_W  (RET_W)
  ) u_sel (
    .cur_ch   (cur_ch),
    .busy     (bus.busy),
    .ret      (bus.ret),
    .expected (bus.expected),
    .busy_sel (busy_sel),
    .ret_sel  (ret_sel),
    .exp_sel  (exp_sel)
  );

  assign ch_onehot = NUM_CH'(1) << cur_ch;
  // Completion is tested first so it wins over a timeout landing on the same cycle.
  assign run_done  = (timer >= CNT_W'(MIN_WAIT)) && !busy_sel;
  assign run_tmo   = (timer == CNT_W'(TIMEOUT));
  assign last_ch   = (cur_ch == CH_IDX_W'(NUM_CH - 1));

`ifdef SJR_RUNNER_STOP_ON_FAIL_EN
  assign stop_now = |(fail_mask & ch_onehot);
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= RST;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.req   = '0;
    case (state)
      RST:   if (cycle == CNT_W'(RST_END)) state_nxt = WAIT;
      WAIT:  if (cycle == CNT_W'(START_CYCLE - 1)) state_nxt = REQ;
      REQ: begin
        bus.req   = ch_onehot;
        state_nxt = RUN;
      end
      RUN: begin
        if (run_done)     state_nxt = CHECK;
        else if (run_tmo) state_nxt = NEXT;
      end
      CHECK: state_nxt = NEXT;
      NEXT:  state_nxt = (last_ch || stop_now) ? DONE : REQ;
      DONE:  if (start) state_nxt = RST;
      default: state_nxt = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dut_reset    <= 1'b0;
      cur_ch       <= '0;
      cycle        <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      timeout_mask <= '0;
      timer        <= '0;
      ret_q        <= '0;
    end else begin
      if (state != DONE && cycle != '1) cycle <= cycle + CNT_W'(1);
      dut_reset <= (state == RST) && (cycle >= CNT_W'(RST_START)) && (cycle <= CNT_W'(RST_END));
      case (state)
        REQ: timer <= '0;
        RUN: begin
          timer <= timer + CNT_W'(1);
          if (run_done) begin
            ret_q <= ret_sel;
          end else if (run_tmo) begin
            timeout_mask <= timeout_mask | ch_onehot;
            fail_mask    <= fail_mask | ch_onehot;
          end
        end
        CHECK: if (ret_q != exp_sel) fail_mask <= fail_mask | ch_onehot;
        NEXT: begin
          if (state_nxt == DONE) begin
            done <= 1'b1;
            pass <= (fail_mask == '0);
          end else begin
            cur_ch <= cur_ch + CH_IDX_W'(1);
          end
        end
        DONE: begin
          // A re-run restarts the count so the DUT reset window repeats exactly.
          if (start) begin
            fail_mask    <= '0;
            timeout_mask <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            cycle        <= '0;
            cur_ch       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sjr_method_runner.sv
// Drives the runner against per-channel stub methods (busy for L cycles, programmable return).
// Expected per-run outcomes are queued when a run is launched and compared when done rises.
module tb_sjr_method_runner;

  localparam int NUM_CH      = 2;
  localparam int RET_W       = 32;
  localparam int RST_START   = 3;
  localparam int RST_END     = 8;
  localparam int START_CYCLE = 100;
  localparam int MIN_WAIT    = 4;
  localparam int TIMEOUT     = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dut_reset;
  logic [4:0]  cur_ch;
  logic [31:0] cycle;
  logic        done;
  logic        pass;
  logic [1:0]  fail_mask;
  logic [1:0]  timeout_mask;

  always #5 clk = ~clk;

  sjr_method_runner_if #(.NUM_CH(NUM_CH), .RET_W(RET_W)) bus ();

  sjr_method_runner #(
    .NUM_CH      (NUM_CH),
    .RET_W       (RET_W),
    .RST_START   (RST_START),
    .RST_END     (RST_END),
    .START_CYCLE (START_CYCLE),
    .MIN_WAIT    (MIN_WAIT),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dut_reset    (dut_reset),
    .bus          (bus),
    .cur_ch       (cur_ch),
    .cycle        (cycle),
    .done         (done),
    .pass         (pass),
    .fail_mask    (fail_mask),
    .timeout_mask (timeout_mask)
  );

  // Stub methods: busy for lat[i] cycles after the request edge, or forever when stuck.
  int          lat[2];
  logic [1:0]  stuck;
  int          cnt[2] = '{0, 0};
  logic [31:0] rv[2];
  logic [31:0] ev[2];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.req[i])     cnt[i] <= lat[i];
      else if (cnt[i] > 0) cnt[i] <= cnt[i] - 1;
    end
  end

  assign bus.busy     = {stuck[1] | (cnt[1] != 0), stuck[0] | (cnt[0] != 0)};
  assign bus.ret      = {rv[1], rv[0]};
  assign bus.expected = {ev[1], ev[0]};

  typedef struct {
    logic [1:0] fm;
    logic [1:0] tm;
    logic       pass;
    logic [4:0] ch;
    int         r1;
    int         done_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int span(input int l);
    return ((l > MIN_WAIT) ? l : MIN_WAIT) + 4;
  endfunction

  task automatic push_exp(input logic [1:0] fm, input logic [1:0] tm, input logic p,
                          input logic [4:0] ch, input int r1, input int dc);
    exp_t e;
    e.fm = fm; e.tm = tm; e.pass = p; e.ch = ch; e.r1 = r1; e.done_cyc = dc;
    sb_q.push_back(e);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".clr_cycle"}, cycle, 0);
    check_eq({tag, ".clr_fm"}, fail_mask, 0);
    check_eq({tag, ".clr_done"}, done, 0);
  endtask

  task automatic wait_done(input string tag, input bit glitch);
    int   rst_lo = -1;
    int   rst_hi = -1;
    int   r0 = -1;
    int   r1 = -1;
    int   multi = 0;
    int   n = 0;
    exp_t e;
    while (!done && n < 3000) begin
      if (dut_reset) begin
        if (rst_lo < 0) rst_lo = int'(cycle);
        rst_hi = int'(cycle);
      end
      if (bus.req[0] && r0 < 0) r0 = int'(cycle);
      if (bus.req[1] && r1 < 0) r1 = int'(cycle);
      if ($countones(bus.req) > 1) multi++;
      if (glitch) start = (cycle == 32'd50);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check_eq({tag, ".done"}, done, 1);
    if (sb_q.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 0, 1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, ".fail_mask"}, fail_mask, e.fm);
      check_eq({tag, ".timeout_mask"}, timeout_mask, e.tm);
      check_eq({tag, ".pass"}, pass, e.pass);
      check_eq({tag, ".cur_ch"}, cur_ch, e.ch);
      check_eq({tag, ".req0_cycle"}, r0, START_CYCLE);
      check_eq({tag, ".req1_cycle"}, r1, e.r1);
      check_eq({tag, ".done_cycle"}, cycle, e.done_cyc);
      check_eq({tag, ".rst_first"}, rst_lo, RST_START + 1);
      check_eq({tag, ".rst_last"}, rst_hi, RST_END + 1);
      check_eq({tag, ".onehot"}, multi, 0);
    end
  endtask

  initial begin
    int n;
    lat   = '{5, 7};
    stuck = 2'b00;
    rv    = '{32'h1111_0000, 32'h0000_0000};
    ev    = '{32'h1111_0000, 32'h2222_0001};

    repeat (3) @(negedge clk);
    check_eq("rst.dut_reset", dut_reset, 0);
    check_eq("rst.req", bus.req, 0);
    check_eq("rst.cur_ch", cur_ch, 0);
    check_eq("rst.cycle", cycle, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.pass", pass, 0);
    check_eq("rst.fail_mask", fail_mask, 0);
    check_eq("rst.timeout_mask", timeout_mask, 0);

    // A: channel 1 returns a wrong value.
    push_exp(2'b10, 2'b00, 1'b0, 5'd1, 100 + span(5), 100 + span(5) + span(7));
    reset = 1'b0;
    wait_done("A", 1'b0);

    // B: identical rerun via start must reproduce A.
    push_exp(2'b10, 2'b00, 1'b0, 5'd1, 100 + span(5), 100 + span(5) + span(7));
    pulse_start("B");
    wait_done("B", 1'b0);

    // C: all returns match; a start pulse in WAIT must be ignored.
    rv[1] = ev[1];
    push_exp(2'b00, 2'b00, 1'b1, 5'd1, 100 + span(5), 100 + span(5) + span(7));
    pulse_start("C");
    wait_done("C", 1'b1);

    // D: channel 0 never drops busy.
    stuck[0] = 1'b1;
`ifdef SJR_RUNNER_STOP_ON_FAIL_EN
    push_exp(2'b01, 2'b01, 1'b0, 5'd0, -1, 100 + TIMEOUT + 3);
`else
    push_exp(2'b01, 2'b01, 1'b0, 5'd1, 100 + TIMEOUT + 3, 100 + TIMEOUT + 3 + span(7));
`endif
    pulse_start("D");
    wait_done("D", 1'b0);
    stuck[0] = 1'b0;

    // E: channel 0 busy low throughout completes at the minimum wait.
    lat[0] = 0;
    push_exp(2'b00, 2'b00, 1'b1, 5'd1, 100 + span(0), 100 + span(0) + span(7));
    pulse_start("E");
    wait_done("E", 1'b0);

    // G: busy drops exactly on the timeout cycle; completion must win.
    lat[0] = TIMEOUT;
    push_exp(2'b00, 2'b00, 1'b1, 5'd1, 100 + span(TIMEOUT), 100 + span(TIMEOUT) + span(7));
    pulse_start("G");
    wait_done("G", 1'b0);

    // F: harness reset while channel 1 is running, then a clean full rerun.
    lat[0] = 5;
    pulse_start("F");
    n = 0;
    while (!bus.req[1] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("F.reach_ch1", bus.req[1], 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("F.mid_req", bus.req, 0);
    check_eq("F.mid_done", done, 0);
    check_eq("F.mid_cycle", cycle, 0);
    check_eq("F.mid_cur_ch", cur_ch, 0);
    check_eq("F.mid_dut_reset", dut_reset, 0);
    push_exp(2'b00, 2'b00, 1'b1, 5'd1, 100 + span(5), 100 + span(5) + span(7));
    reset = 1'b0;
    wait_done("F", 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
